regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the single-write, two-read CPU register bank.
- Sits in the CPU datapath between decode (read addresses, issue tags) and writeback (two retire ports, e.g. ALU and memory).
- Adds the following over the previous bank:
  - configurable width, depth and read-port count;
  - two write ports with fixed priority;
  - a per-register pending-write scoreboard for the multicycle/pipelined cores;
  - a monitor port for VGA/display.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must be ≤ 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 31, hard-wired zero register index.
- STACK_REG, 28, stack pointer index.
- STACK_INIT, 64'h0000_0000_0000_3FFC, reset value of STACK_REG.

Ports:
- iCLK  in  1  clock; writes and scoreboard update on falling edge.
- iRST  in  1  reset.
- iWE0  in  1  write enable, port 0.
- iWA0  in  ADDR_W  write address, port 0.
- iWD0  in  DATA_W  write data, port 0.
- iWE1  in  1  write enable, port 1 (priority port).
- iWA1  in  ADDR_W  write address, port 1.
- iWD1  in  DATA_W  write data, port 1.
- iRA  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- oRD  out  NUM_RD*DATA_W  packed read data, same packing.
- oRdBusy  out  NUM_RD  scoreboard busy bit of each read address.
- iIssue  in  1  mark iIssueReg as pending-write.
- iIssueReg  in  ADDR_W  destination register being issued.
- oBusy  out  NUM_REGS  scoreboard vector.
- oPendCnt  out  ADDR_W+1  count of busy registers.
- iMonSel  in  ADDR_W  monitor select.
- oMonData  out  DATA_W  monitor read data.

Behaviour:
- Reset: iRST, asynchronous, active-high.
  - All registers clear to 0, except STACK_REG = STACK_INIT.
  - oBusy, oPendCnt = 0.
  - Reset asserted mid-operation overrides any same-edge write or issue.
  - Initial block applies the same values for simulation.
- Reads and monitor: combinational, zero latency.
  - Read address ZERO_REG or ≥ NUM_REGS returns 0; its busy bit reads 0.
- Writes commit on the falling edge when enabled.
  - Address ZERO_REG or ≥ NUM_REGS is ignored.
  - iWE0 and iWE1 to the same address: port 1 data wins.
  - Written data is visible on oRD after that falling edge, i.e. within the same clock period for the rising-edge consumer.
- Scoreboard, on the falling edge:
  - Retire: any enabled write clears busy[WA].
  - Issue: iIssue sets busy[iIssueReg]; issue to ZERO_REG is ignored.
  - Issue and retire to the same register on the same edge: issue wins, busy stays 1.
  - Issue to an already-busy register keeps it at 1; no error, no counter change.
  - Retire to a non-busy register is legal; the register is written, busy is unchanged.
- oPendCnt: registered, always equals popcount(oBusy).
  - Updated on the same edge with net delta −2..+1; never wraps.
- Write data width is exactly DATA_W; no sign or zero extension.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each read port combinationally forwards the matching write data.
  - Condition: write port enabled with WA == RA and RA not ZERO_REG. Port 1 is preferred over port 0.
  - oRdBusy for that port is forced to 0 while forwarding.
  - Same-cycle read-after-write therefore returns new data before the falling edge.
- Undefined: reads return array contents only; new data appears after the falling edge.

Test Plan:
- Reset check: pulse iRST asynchronously → every oRD = 0, reg28 = 64'h3FFC, oBusy = 0, oPendCnt = 0.
- Zero-register protection: iWE0 = 1, iWA0 = 31, iWD0 = 64'hDEAD → read reg31 = 0, oBusy[31] = 0.
- Dual-write conflict: both ports write reg5, WD0 = 64'h1111, WD1 = 64'h2222 → after falling edge reg5 = 64'h2222.
- Scoreboard counting:
  - issue reg3, reg4, reg7 → oPendCnt = 3, oRdBusy set for RA = 3;
  - retire reg3 via port 0 and reg4 via port 1 on the same edge → oPendCnt = 1.
- Issue/retire collision: issue reg9 while port 0 retires reg9 → busy[9] = 1, reg9 = new data.
- Bypass and mid-operation reset:
  - with REGFILE_BYPASS_EN, write reg2 = 64'hABCD while RA0 = 2, checked before the falling edge → oRD0 = 64'hABCD; without the macro → old value;
  - iRST raised mid-cycle while a write is pending → no write lands.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port CPU register file: two prioritised write ports, NUM_RD combinational read ports,
// pending-write scoreboard and a display monitor port. Optional read forwarding: REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 5,
    parameter int                NUM_REGS   = 32,
    parameter int                NUM_RD     = 2,
    parameter int                ZERO_REG   = 31,
    parameter int                STACK_REG  = 28,
    parameter logic [DATA_W-1:0] STACK_INIT = 64'h0000_0000_0000_3FFC
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iWE0,
    input  logic [ADDR_W-1:0]          iWA0,
    input  logic [DATA_W-1:0]          iWD0,
    input  logic                       iWE1,
    input  logic [ADDR_W-1:0]          iWA1,
    input  logic [DATA_W-1:0]          iWD1,
    input  logic [NUM_RD*ADDR_W-1:0]   iRA,
    output logic [NUM_RD*DATA_W-1:0]   oRD,
    output logic [NUM_RD-1:0]          oRdBusy,
    input  logic                       iIssue,
    input  logic [ADDR_W-1:0]          iIssueReg,
    output logic [NUM_REGS-1:0]        oBusy,
    output logic [ADDR_W:0]            oPendCnt,
    input  logic [ADDR_W-1:0]          iMonSel,
    output logic [DATA_W-1:0]          oMonData
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    pend_cnt;
    logic                wr0_ok;
    logic                wr1_ok;
    logic                iss_ok;

    // Addresses that name a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && (int'(a) != ZERO_REG);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign wr0_ok = iWE0 && addr_ok(iWA0);
    assign wr1_ok = iWE1 && addr_ok(iWA1);
    assign iss_ok = iIssue && addr_ok(iIssueReg);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(negedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == STACK_REG) ? STACK_INIT : '0;
            end
        end else begin
            if (wr0_ok) regs[iWA0] <= iWD0;
            if (wr1_ok) regs[iWA1] <= iWD1;
        end
    end

    // Retires clear first, then issue sets, so a same-edge issue keeps the bit high.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[iWA0] = 1'b0;
        if (wr1_ok) busy_nxt[iWA1] = 1'b0;
        if (iss_ok) busy_nxt[iIssueReg] = 1'b1;
    end

    always_ff @(negedge iCLK or posedge iRST) begin
        if (iRST) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= popcount(busy_nxt);
        end
    end

    assign oBusy    = busy;
    assign oPendCnt = pend_cnt;

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        oRD     = '0;
        oRdBusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = iRA[k*ADDR_W +: ADDR_W];
            if (addr_ok(ra)) begin
                oRD[k*DATA_W +: DATA_W] = regs[ra];
                oRdBusy[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr1_ok && (iWA1 == ra)) begin
                    oRD[k*DATA_W +: DATA_W] = iWD1;
                    oRdBusy[k]              = 1'b0;
                end else if (wr0_ok && (iWA0 == ra)) begin
                    oRD[k*DATA_W +: DATA_W] = iWD0;
                    oRdBusy[k]              = 1'b0;
                end
`else
`endif
            end
        end
    end

    assign oMonData = addr_ok(iMonSel) ? regs[iMonSel] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    logic         iCLK = 1'b0;
    logic         iRST;
    logic         iWE0, iWE1, iIssue;
    logic [4:0]   iWA0, iWA1, iIssueReg, iMonSel;
    logic [63:0]  iWD0, iWD1;
    logic [9:0]   iRA;
    logic [127:0] oRD;
    logic [1:0]   oRdBusy;
    logic [31:0]  oBusy;
    logic [5:0]   oPendCnt;
    logic [63:0]  oMonData;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] m_reg [32];
    bit          m_busy [32];

    regfile_mp dut (
        .iCLK(iCLK), .iRST(iRST),
        .iWE0(iWE0), .iWA0(iWA0), .iWD0(iWD0),
        .iWE1(iWE1), .iWA1(iWA1), .iWD1(iWD1),
        .iRA(iRA), .oRD(oRD), .oRdBusy(oRdBusy),
        .iIssue(iIssue), .iIssueReg(iIssueReg),
        .oBusy(oBusy), .oPendCnt(oPendCnt),
        .iMonSel(iMonSel), .oMonData(oMonData)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 64'd0;
            m_busy[i] = 1'b0;
        end
        m_reg[28] = 64'h3FFC;
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (iWE1 && iWA1 == ra) return iWD1;
        if (iWE0 && iWA0 == ra) return iWD0;
`endif
        return m_reg[ra];
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] ra);
        if (ra == 5'd31) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((iWE1 && iWA1 == ra) || (iWE0 && iWA0 == ra)) return 1'b0;
`endif
        return m_busy[ra];
    endfunction

    function automatic logic [31:0] exp_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 6'(c);
    endfunction

    task automatic model_commit();
        if (iWE0 && iWA0 != 5'd31) m_reg[iWA0] = iWD0;
        if (iWE1 && iWA1 != 5'd31) m_reg[iWA1] = iWD1;
        if (iWE0 && iWA0 != 5'd31) m_busy[iWA0] = 1'b0;
        if (iWE1 && iWA1 != 5'd31) m_busy[iWA1] = 1'b0;
        if (iIssue && iIssueReg != 5'd31) m_busy[iIssueReg] = 1'b1;
    endtask

    task automatic check_reads(input string ph);
        chk({ph, "_rd0"}, oRD[63:0], exp_rd(iRA[4:0]));
        chk({ph, "_rd1"}, oRD[127:64], exp_rd(iRA[9:5]));
        chk({ph, "_rbusy0"}, 64'(oRdBusy[0]), 64'(exp_rbusy(iRA[4:0])));
        chk({ph, "_rbusy1"}, 64'(oRdBusy[1]), 64'(exp_rbusy(iRA[9:5])));
        chk({ph, "_mon"}, oMonData, (iMonSel == 5'd31) ? 64'd0 : m_reg[iMonSel]);
    endtask

    task automatic check_all();
        check_reads("post");
        chk("busy_vec", 64'(oBusy), 64'(exp_busy_vec()));
        chk("pend_cnt", 64'(oPendCnt), 64'(exp_cnt()));
    endtask

    task automatic drive(input logic we0, input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic we1, input logic [4:0] wa1, input logic [63:0] wd1,
                         input logic iss, input logic [4:0] ireg,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] mon);
        @(posedge iCLK);
        #1;
        iWE0 = we0; iWA0 = wa0; iWD0 = wd0;
        iWE1 = we1; iWA1 = wa1; iWD1 = wd1;
        iIssue = iss; iIssueReg = ireg;
        iRA = {ra1, ra0}; iMonSel = mon;
    endtask

    task automatic commit();
        @(negedge iCLK);
        #1;
        model_commit();
        check_all();
    endtask

    task automatic run_cycle(input logic we0, input logic [4:0] wa0, input logic [63:0] wd0,
                             input logic we1, input logic [4:0] wa1, input logic [63:0] wd1,
                             input logic iss, input logic [4:0] ireg,
                             input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] mon);
        drive(we0, wa0, wd0, we1, wa1, wd1, iss, ireg, ra0, ra1, mon);
        #1;
        check_reads("pre");
        commit();
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [4:0] hot [4] = '{5'd3, 5'd5, 5'd9, 5'd31};
        if ($urandom_range(0, 3) == 0) return hot[$urandom_range(0, 3)];
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        iRST = 1'b1;
        iWE0 = 0; iWA0 = 0; iWD0 = 0; iWE1 = 0; iWA1 = 0; iWD1 = 0;
        iIssue = 0; iIssueReg = 0; iRA = 0; iMonSel = 0;
        model_reset();
        #13 iRST = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            iMonSel = 5'(i);
            #1;
            chk("rst_mon", oMonData, (i == 28) ? 64'h3FFC : 64'd0);
        end
        iRA = {5'd28, 5'd0};
        #1;
        chk("rst_rd0", oRD[63:0], 64'd0);
        chk("rst_rd28", oRD[127:64], 64'h3FFC);
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_cnt", 64'(oPendCnt), 64'd0);

        // zero register protection
        run_cycle(1, 5'd31, 64'hDEAD, 0, 0, 0, 1, 5'd31, 5'd31, 5'd28, 5'd31);
        chk("zero_rd", oRD[63:0], 64'd0);
        chk("zero_busy", 64'(oBusy[31]), 64'd0);

        // dual write conflict
        run_cycle(1, 5'd5, 64'h1111, 1, 5'd5, 64'h2222, 0, 0, 5'd5, 5'd0, 5'd5);
        chk("dual_wr", oRD[63:0], 64'h2222);

        // scoreboard counting
        run_cycle(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4, 5'd0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 5'd4, 5'd3, 5'd4, 5'd0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 5'd0);
        chk("sb_cnt3", 64'(oPendCnt), 64'd3);
        chk("sb_rbusy3", 64'(oRdBusy[0]), 64'd1);
        run_cycle(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0, 0, 5'd3, 5'd4, 5'd3);
        chk("sb_cnt1", 64'(oPendCnt), 64'd1);

        // issue and retire on the same register
        run_cycle(1, 5'd9, 64'h99, 0, 0, 0, 1, 5'd9, 5'd9, 5'd7, 5'd9);
        chk("coll_busy9", 64'(oBusy[9]), 64'd1);
        chk("coll_rd9", oRD[63:0], 64'h99);

        // read-after-write in the same cycle
        run_cycle(1, 5'd2, 64'h1234, 0, 0, 0, 0, 0, 5'd2, 5'd0, 5'd2);
        drive(1, 5'd2, 64'hABCD, 0, 0, 0, 0, 0, 5'd2, 5'd9, 5'd2);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd0", oRD[63:0], 64'hABCD);
`else
        chk("bypass_rd0", oRD[63:0], 64'h1234);
`endif
        commit();
        chk("raw_after_edge", oRD[63:0], 64'hABCD);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            run_cycle(1'($urandom), rnd_addr(), {$urandom, $urandom},
                      1'($urandom), rnd_addr(), {$urandom, $urandom},
                      1'($urandom), rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr());
        end

        // asynchronous reset mid-cycle with a write and issue pending
        run_cycle(1, 5'd6, 64'h55, 0, 0, 0, 1, 5'd6, 5'd6, 5'd28, 5'd6);
        drive(1, 5'd6, 64'hAAAA, 1, 5'd28, 64'hBBBB, 1, 5'd7, 5'd6, 5'd28, 5'd6);
        #2 iRST = 1'b1;
        #1;
        chk("rst_async_cnt", 64'(oPendCnt), 64'd0);
        model_reset();
        @(negedge iCLK);
        #1 iRST = 1'b0;
        #1;
        chk("rst_mid_reg6", oMonData, 64'd0);
        check_all();
        iWE0 = 0; iWE1 = 0; iIssue = 0;
        #1;
        chk("rst_mid_reg28", oRD[127:64], 64'h3FFC);
        chk("rst_mid_rd6", oRD[63:0], 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
